edge_bit_packer: RTL
====================

Name: edge_bit_packer

Overview:
- Downstream consumer of `sobel_filter`.
- Takes the `gradient`/`gradient_valid` stream, binarizes each gradient against a programmable threshold, and packs 8 edge bits per byte, LSB-first.
- Packed bytes go through a small FIFO to a valid/ready byte stream carrying row-end and frame-start markers, for the frame writer / external memory path.
- `sobel_filter` cannot be stalled, so the block never backpressures it; losses are flagged instead.

Parameters:
- ROW_WIDTH, 640, input image width; the valid gradient region is ROW_WIDTH-2 columns.
- HEIGHT, 480, input image height; the valid region is HEIGHT-2 rows.
- GRAD_W, 11, gradient width.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- gradient  in  GRAD_W  gradient magnitude from `sobel_filter`.
- gradient_valid  in  1  qualifies gradient; may be high every cycle.
- threshold  in  GRAD_W  edge threshold, sampled at frame start.
- out_data  out  8  packed edge bits; bit k = column 8n+k of the row.
- out_last  out  1  byte is the last of a valid row.
- out_sof  out  1  byte is the first of a frame.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head when out_valid & out_ready.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is pushed.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async): all outputs 0, column/row counters 0, pack register 0, FIFO emptied, thr_q loaded with 0. Release is synchronous to clk.
- Geometry:
  - VW=ROW_WIDTH-2, VH=HEIGHT-2.
  - BPR=ceil(VW/8) bytes per row.
  - REM=VW mod 8 (0 means the last byte is full).
- Threshold: on each gradient_valid with col==0 and row==0, thr_q<=threshold. That beat itself uses the live threshold; all later beats of the frame use thr_q.
- Binarize: edge = (gradient >= thr_q); an unsigned GRAD_W compare.
- Packing: each valid beat writes edge into pack bit (col mod 8), then col++.
- A byte is pushed on the same clock edge as the beat that completes it:
  - when col mod 8 == 7, or
  - when col == VW-1 (partial last byte; unused upper bits = 0).
- The pack register clears after each push.
- Pushed entry = {data, last = (col==VW-1), sof = (col<8 and row==0)}.
- End of row: on col==VW-1, col<=0 and row++.
  - On row==VH-1 the row wraps to 0 and frame_done pulses on the next cycle.
  - The next valid beat starts a new frame (sof, threshold resample).
- Latency: a byte pushed at edge E gives out_valid=1 in the cycle after E if the FIFO was empty. Fall-through head; no extra register stage.
- Output handshake:
  - out_data/out_last/out_sof are stable while out_valid & !out_ready.
  - A pop occurs on out_valid & out_ready.
  - out_data is don't-care when out_valid=0 (drive 0).
- Full:
  - push while full and no simultaneous pop → byte dropped, overflow<=1 (sticky until reset), counters still advance.
  - push while full with a simultaneous pop → accepted, no overflow.
- Empty: push and pop never coincide on the same entry; the head is only popped when out_valid=1.
- Gaps in gradient_valid: state holds, no timeout.
- Reset mid-frame: partial pack discarded, FIFO flushed. The next frame starts at col=0, row=0.

Decomposition:
- Package `edge_pkg`:
  - localparams VW, VH, BPR, REM, PTR_W=$clog2(FIFO_DEPTH).
  - typedef struct packed {logic [7:0] data; logic last; logic sof;} edge_byte_t.
- One sub-module: `edge_fifo`, a synchronous FIFO of edge_byte_t.
  - Ports: push, pop, full, empty, head.
  - Uses a count register to disambiguate full/empty; same clk and async active-low rst.

Test Plan:
Small geometry: ROW_WIDTH=20, HEIGHT=6 → VW=18, VH=4, BPR=3, REM=2; FIFO_DEPTH=16; out_ready=1 unless stated.
- All-zero gradients for 72 beats, threshold=1 → 12 bytes of 0x00; out_last on bytes 3,6,9,12; out_sof on byte 1 only; one frame_done pulse; overflow=0.
- All gradients=100, threshold=100 → per row 0xFF,0xFF,0x03 (partial byte, upper bits 0); 12 bytes total.
- Columns alternate 0/200 (col0=0), threshold=128 → per row 0xAA,0xAA,0x02; first out_valid one cycle after the 8th beat's edge.
- FIFO_DEPTH=4, out_ready=0 for the whole frame → FIFO holds the first 4 bytes, overflow=1 after the 5th push. Then raise out_ready → exactly 4 bytes out in order: 0xFF,0xFF,0x03(last),0xFF (gradients=100). overflow stays 1 until rst.
- threshold changed 100→300 after 10 beats, gradients=200 → frame 1 all-edge bytes (0xFF/0x03); frame 2 all 0x00.
- rst pulsed low after 11 beats → outputs 0 immediately (async); post-release frame gives a full 12 bytes with sof on byte 1; no leftover bits.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg: shared types and geometry for the edge bit packer.
//   edge_byte_t  - one packed output byte plus its row-end / frame-start markers
//   VW, VH       - valid gradient region for the default image geometry
//   BPR, REM     - bytes per valid row and bits used in the last byte (0 = full)
//   PTR_W        - FIFO pointer width for the default FIFO depth
// Modules carrying their own geometry parameters use bytesPerRow()/remBits()
// so that the same arithmetic holds for non-default image sizes.
package edge_pkg;

  localparam int DEF_ROW_WIDTH  = 640;
  localparam int DEF_HEIGHT     = 480;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int VW    = DEF_ROW_WIDTH - 2;
  localparam int VH    = DEF_HEIGHT - 2;
  localparam int BPR   = (VW + 7) / 8;
  localparam int REM   = VW % 8;
  localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       sof;
  } edge_byte_t;

  // Number of bytes needed to hold one valid row of vw edge bits.
  function automatic int bytesPerRow(input int vw);
    return (vw + 7) / 8;
  endfunction

  // Bits occupied in the final byte of a row; 0 means that byte is full.
  function automatic int remBits(input int vw);
    return vw % 8;
  endfunction

endpackage

// File: rtl/edge_fifo.sv
// edge_fifo: synchronous FIFO of edge_byte_t with a fall-through head.
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset, empties the FIFO
//   i_push   - write i_data (ignored when full unless a pop happens this cycle)
//   i_pop    - remove the head entry (ignored when empty)
//   i_data   - entry to write
//   o_full   - all DEPTH entries in use
//   o_empty  - no entries in use
//   o_head   - oldest entry, visible combinationally from storage
module edge_fifo
  import edge_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  edge_byte_t i_data,
  output logic       o_full,
  output logic       o_empty,
  output edge_byte_t o_head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  edge_byte_t        r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  // Qualify the requests against the occupancy. When full, a write is still
  // accepted if the head leaves on the same edge: the write lands in the slot
  // the read pointer is just vacating, and the head is read out before the edge.
  always_comb begin
    o_full   = (r_count == CNT_W'(DEPTH));
    o_empty  = (r_count == '0);
    w_doPop  = i_pop && !o_empty;
    w_doPush = i_push && (!o_full || w_doPop);
    o_head   = r_mem[r_rdPtr];
  end

  // Storage array; contents are only meaningful below the count, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // register tells full from empty when the pointers are equal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/edge_bit_packer.sv
// edge_bit_packer: binarizes the sobel_filter gradient stream against a
// per-frame threshold and packs 8 edge bits per byte, LSB-first, into a
// valid/ready byte stream. The upstream cannot stall, so a full FIFO drops
// bytes and raises a sticky overflow flag instead of pushing back.
//   clk, rst            - clock and asynchronous active-low reset
//   gradient(_valid)    - gradient magnitude and its qualifier
//   threshold           - edge threshold, captured on the first beat of a frame
//   out_data/last/sof   - FIFO head: packed bits, row-end and frame-start markers
//   out_valid/out_ready - output handshake
//   frame_done          - one-cycle pulse after the last byte of a frame is pushed
//   overflow            - sticky: a byte was lost to a full FIFO
module edge_bit_packer
  import edge_pkg::*;
#(
  parameter int ROW_WIDTH  = 640,
  parameter int HEIGHT     = 480,
  parameter int GRAD_W     = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GRAD_W-1:0] gradient,
  input  logic              gradient_valid,
  input  logic [GRAD_W-1:0] threshold,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              out_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overflow
);

  localparam int VW_L  = ROW_WIDTH - 2;
  localparam int VH_L  = HEIGHT - 2;
  // The column counter is kept at least 4 bits wide so that its low three
  // bits give the bit slot and the "first byte of the row" test (col < 8)
  // stays meaningful for very narrow images.
  localparam int COL_W = ($clog2(VW_L) > 4) ? $clog2(VW_L) : 4;
  localparam int ROW_W = ($clog2(VH_L) > 1) ? $clog2(VH_L) : 1;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [7:0]        r_pack;
  logic [GRAD_W-1:0] r_thr;
  logic              r_frameDone;
  logic              r_overflow;

  logic              w_frameStart;
  logic [GRAD_W-1:0] w_thrEff;
  logic              w_edge;
  logic [7:0]        w_packNext;
  logic              w_colLast;
  logic              w_rowLast;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  edge_byte_t        w_pushByte;
  edge_byte_t        w_head;

  // Per-beat datapath. The first beat of a frame compares against the live
  // threshold, because thr_q only picks it up on that same edge. The byte is
  // assembled from the pack register plus the current bit so it can be pushed
  // on the edge of the beat that completes it; partial last bytes keep their
  // upper bits at 0 because the pack register is cleared after every push.
  always_comb begin
    w_frameStart        = (r_col == '0) && (r_row == '0);
    w_thrEff            = w_frameStart ? threshold : r_thr;
    w_edge              = (gradient >= w_thrEff);
    w_packNext          = r_pack | (8'(w_edge) << r_col[2:0]);
    w_colLast           = (r_col == COL_W'(VW_L - 1));
    w_rowLast           = (r_row == ROW_W'(VH_L - 1));
    w_push              = gradient_valid && ((r_col[2:0] == 3'd7) || w_colLast);
    w_pushByte.data     = w_packNext;
    w_pushByte.last     = w_colLast;
    w_pushByte.sof      = (r_col < COL_W'(8)) && (r_row == '0);
    w_pop               = !w_empty && out_ready;
    w_accept            = w_push && (!w_full || w_pop);
  end

  // Geometry counters, threshold capture, pack register and status flags.
  // Counters advance on every valid beat even when the byte is dropped, so a
  // lost byte never shifts the framing of what follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pack      <= '0;
      r_thr       <= '0;
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (gradient_valid) begin
        if (w_frameStart) begin
          r_thr <= threshold;
        end
        r_pack <= w_push ? 8'h00 : w_packNext;
        if (w_colLast) begin
          r_col <= '0;
          if (w_rowLast) begin
            r_row       <= '0;
            r_frameDone <= 1'b1;
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  edge_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_data  (w_pushByte),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Output stream: the FIFO head falls straight through; payload fields are
  // forced to 0 whenever there is nothing valid to present.
  always_comb begin
    out_valid  = !w_empty;
    out_data   = out_valid ? w_head.data : 8'h00;
    out_last   = out_valid && w_head.last;
    out_sof    = out_valid && w_head.sof;
    frame_done = r_frameDone;
    overflow   = r_overflow;
  end

endmodule
